// File: rtl/irs_block_allocator_if.sv
// irs_block_allocator_if: request/return/status bundle between trigger logic and the block allocator
interface irs_block_allocator_if #(
  parameter int ADDR_BITS = 7
);
  logic                 alloc_req;
  logic                 alloc_ack;
  logic [ADDR_BITS-1:0] alloc_block;
  logic                 free;
  logic [ADDR_BITS-1:0] free_block;
  logic                 err_clr;
  logic [ADDR_BITS:0]   free_count;
  logic                 ready;
  logic                 dead;
  logic                 err;

  modport master (
    output alloc_req, free, free_block, err_clr,
    input  alloc_ack, alloc_block, free_count, ready, dead, err
  );

  modport slave (
    input  alloc_req, free, free_block, err_clr,
    output alloc_ack, alloc_block, free_count, ready, dead, err
  );
endinterface

// File: rtl/irs_block_allocator.sv
// irs_block_allocator: circular free list of IRS sample blocks with reserve-based dead-time inhibit
module irs_block_allocator #(
  parameter int NUM_BLOCKS = 128,
  parameter int ADDR_BITS  = 7,
  parameter int RESERVE    = 23,
  parameter int HYSTERESIS = 2
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  irs_block_allocator_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_BITS:0] FULL   = (ADDR_BITS+1)'(NUM_BLOCKS);
  localparam logic [ADDR_BITS:0] RES_LO = (ADDR_BITS+1)'(RESERVE);
  localparam logic [ADDR_BITS:0] RES_HI = (ADDR_BITS+1)'(RESERVE + HYSTERESIS);

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] mem [NUM_BLOCKS];
  logic [ADDR_BITS-1:0] head, tail, init_idx;
  logic [ADDR_BITS:0]   count;
  logic                 grant, put, err_set, init_last;

  assign bus.free_count = count;
  assign bus.ready      = state == RUN;

  // Grant uses the registered count, so a same-cycle free can never bypass to the requester
  always_comb begin
    init_last = init_idx == ADDR_BITS'(NUM_BLOCKS - 1);
    grant     = state == RUN && bus.alloc_req && count != '0 && !bus.alloc_ack;
    put       = state == RUN && bus.free && count != FULL;
    err_set   = bus.free && (state == INIT || count == FULL);
    state_n   = (state == INIT && init_last) ? RUN : state;
  end

  // State register; RUN is left only through reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= INIT;
    else          state <= state_n;
  end

  // Free-list RAM: identity fill during INIT, returned blocks appended at tail in RUN
  always_ff @(posedge clk_i) begin
    if (state == INIT) mem[init_idx] <= init_idx;
    else if (put)      mem[tail] <= bus.free_block;
  end

  // Pointers, count, ack/block outputs and the dead/err status flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.alloc_ack   <= 1'b0;
      bus.alloc_block <= '0;
      bus.dead        <= 1'b1;
      bus.err         <= 1'b0;
      count           <= '0;
      head            <= '0;
      tail            <= '0;
      init_idx        <= '0;
    end else begin
      bus.alloc_ack <= grant;
      bus.err       <= err_set | (bus.err & ~bus.err_clr);
      if (grant) bus.alloc_block <= mem[head];
      if (state == INIT) begin
        bus.dead <= 1'b1;
        init_idx <= init_idx + ADDR_BITS'(1);
        if (init_last) begin
          count <= FULL;
          head  <= '0;
          tail  <= '0;
        end
      end else begin
        bus.dead <= count < RES_LO ? 1'b1 : count >= RES_HI ? 1'b0 : bus.dead;
        head     <= head + ADDR_BITS'(grant);
        tail     <= tail + ADDR_BITS'(put);
        count    <= count + (ADDR_BITS+1)'(put) - (ADDR_BITS+1)'(grant);
      end
    end
  end
endmodule

// File: tb/tb_irs_block_allocator.sv
// tb_irs_block_allocator: randomized scoreboard bench against a queue-based free-list model
module tb_irs_block_allocator;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  irs_block_allocator_if #(.ADDR_BITS(7)) bus();

  irs_block_allocator dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  int freeq[$];
  int expq[$];
  bit m_run, m_ack, m_dead, m_err;
  int m_init, m_last;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the free list is a plain queue of block numbers
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      freeq.delete();
      expq.delete();
      m_run = 0; m_ack = 0; m_dead = 1; m_err = 0; m_init = 0; m_last = 0;
    end else begin
      bit g, f, e;
      e = bus.free && (!m_run || freeq.size() == 128);
      g = m_run && bus.alloc_req && freeq.size() > 0 && !m_ack;
      f = m_run && bus.free && freeq.size() < 128;
      if (!m_run) m_dead = 1;
      else if (freeq.size() < 23) m_dead = 1;
      else if (freeq.size() >= 25) m_dead = 0;
      if (e) m_err = 1;
      else if (bus.err_clr) m_err = 0;
      if (g) begin
        m_last = freeq.pop_front();
        expq.push_back(m_last);
      end
      if (f) freeq.push_back(int'(bus.free_block));
      m_ack = g;
      if (!m_run) begin
        m_init++;
        if (m_init == 128) begin
          m_run = 1;
          for (int i = 0; i < 128; i++) freeq.push_back(i);
        end
      end
    end
  end

  // Monitor: pops an expected block on every ack and checks status outputs each cycle
  always @(negedge clk_i) begin
    chk("ack", bus.alloc_ack, m_ack);
    if (bus.alloc_ack) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected: got block %0d expected no ack at %0t", bus.alloc_block, $time);
      end else chk("ack_block", bus.alloc_block, expq.pop_front());
    end
    chk("block_held", bus.alloc_block, m_last);
    chk("free_count", bus.free_count, m_run ? freeq.size() : 0);
    chk("ready", bus.ready, m_run);
    chk("dead", bus.dead, m_dead);
    chk("err", bus.err, m_err);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 300) begin
      step();
      n++;
    end
    if (!bus.ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ready still %0d after %0d cycles", bus.ready, n);
    end
  endtask

  initial begin
    bus.alloc_req  = 1'b0;
    bus.free       = 1'b0;
    bus.free_block = '0;
    bus.err_clr    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (10) step();
    bus.free = 1'b1; bus.free_block = 7'd3;
    step();
    bus.free = 1'b0;
    wait_ready();
    step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    bus.alloc_req = 1'b1;
    repeat (270) step();
    bus.free = 1'b1; bus.free_block = 7'd5;
    step();
    bus.free = 1'b0;
    repeat (6) step();
    bus.alloc_req = 1'b0;
    step();
    for (int i = 0; i < 129; i++) begin
      bus.free = 1'b1;
      bus.free_block = 7'(i);
      step();
    end
    bus.free = 1'b0;
    repeat (2) step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    bus.alloc_req = 1'b1;
    repeat (128) step();
    for (int i = 0; i < 20; i++) begin
      bus.free = 1'b1;
      bus.free_block = 7'($urandom_range(0, 127));
      step();
    end
    bus.free = 1'b0;
    bus.alloc_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.alloc_req  = 1'($urandom_range(0, 1));
      bus.free       = ($urandom_range(0, 2) == 0);
      bus.free_block = 7'($urandom_range(0, 127));
      bus.err_clr    = ($urandom_range(0, 30) == 0);
      step();
    end
    bus.free = 1'b0;
    bus.err_clr = 1'b0;
    bus.alloc_req = 1'b1;
    repeat (7) step();
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_ack", bus.alloc_ack, 0);
    chk("rst_block", bus.alloc_block, 0);
    chk("rst_count", bus.free_count, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_dead", bus.dead, 1);
    chk("rst_err", bus.err, 0);
    step();
    rst_n_i = 1'b1;
    wait_ready();
    repeat (10) step();
    bus.alloc_req = 1'b0;
    repeat (3) step();
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_acks: got %0d outstanding expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
